demux_stream_1ton: RTL and testbench

DEMUX_STREAM_1TON -- requirements
Module: demux_stream_1ton

---
 rtl/demux_stream_1ton.sv | 100 ++++++++++
 tb/tb_demux_stream_1ton.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton: 1-to-N stream demultiplexer with a one-entry output
// register per channel. Beats are routed by in_sel; out-of-range selects are
// discarded and counted in a saturating drop counter.
// Optional feature: define DEMUX_BCAST_EN to add the in_bcast port, which
// loads one beat into every channel at once.
module demux_stream_1ton #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_data,
`ifdef DEMUX_BCAST_EN
  input  logic                     in_bcast,
`endif
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [7:0]               drop_cnt
);

  logic              bcast;
  logic [NUM_CH-1:0] hit;     // one-hot decode of in_sel (all zero if out of range)
  logic [NUM_CH-1:0] free;    // channel can take a beat this cycle
  logic [NUM_CH-1:0] load;    // channel register loads in_data at the next edge
  logic              sel_ok;
  logic              accept;
  logic              drop_evt;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Decode the destination; comparing against each index avoids indexing
  // per-channel vectors with an out-of-range select.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    hit  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit[k] = (in_sel == SEL_W'(k));
    end
    free   = ~out_valid | out_ready;
    sel_ok = |hit;
  end

  // Ready: held low in reset; otherwise depends only on state, select and
  // out_ready, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (bcast)        in_ready = &free;
      else if (!sel_ok) in_ready = 1'b1;
      else              in_ready = |(hit & free);
    end
  end

  // Transfer decode: which registers load, and whether the beat is dropped.
  always_comb begin
    accept   = in_valid && in_ready;
    load     = '0;
    if (accept) load = bcast ? {NUM_CH{1'b1}} : hit;
    drop_evt = accept && !bcast && !sel_ok;
  end

  // Per-channel output registers: load wins over drain, so a register being
  // emptied and refilled in the same cycle keeps valid high with no bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the data registers are reset too; there is one word per channel
      // and out_data is required to read zero after reset.
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load[k]) begin
          out_valid[k]                 <= 1'b1;
          out_data[k*DATA_W +: DATA_W] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of beats discarded for an out-of-range select.
  always_ff @(posedge clk) begin
    if (rst)                              drop_cnt <= 8'd0;
    else if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: directed scenarios plus randomized traffic,
// checked against a per-channel slot model. A second 6-channel instance
// exercises out-of-range selects and drop counter saturation.
module tb_demux_stream_1ton;

  localparam int DW = 8;
  localparam int NC = 8;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_bcast;
  logic [SW-1:0]     in_sel;
  logic [DW-1:0]     in_data;
  logic [NC-1:0]     out_ready;
  logic              in_ready;
  logic [NC-1:0]     out_valid;
  logic [NC*DW-1:0]  out_data;
  logic [7:0]        drop_cnt;

  logic              v6;
  logic [2:0]        sel6;
  logic [7:0]        d6;
  logic [5:0]        ordy6;
  logic              rdy6;
  logic [5:0]        ov6;
  logic [47:0]       od6;
  logic [7:0]        drop6;

  always #5 clk = ~clk;

  demux_stream_1ton #(.DATA_W(DW), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
`ifdef DEMUX_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  demux_stream_1ton #(.DATA_W(8), .NUM_CH(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(rdy6),
    .in_sel(sel6), .in_data(d6),
`ifdef DEMUX_BCAST_EN
    .in_bcast(1'b0),
`endif
    .out_valid(ov6), .out_ready(ordy6), .out_data(od6),
    .drop_cnt(drop6)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each channel is a slot that either holds a beat or not.
  bit        m_full [NC];
  logic [7:0] m_data [NC];
  int        m_drop;

  function automatic bit can_take(input int k);
    return !m_full[k] || out_ready[k];
  endfunction

  function automatic bit exp_ready();
    bit all_free = 1'b1;
    if (rst) return 1'b0;
    if (in_bcast) begin
      for (int k = 0; k < NC; k++) if (!can_take(k)) all_free = 1'b0;
      return all_free;
    end
    if (int'(in_sel) >= NC) return 1'b1;
    return can_take(int'(in_sel));
  endfunction

  // Compare all outputs with the model, advance the model over one edge.
  // Called just after a negedge with the cycle's inputs already driven.
  task automatic tick();
    logic [NC-1:0]    ev;
    logic [NC*DW-1:0] ed, ad;
    bit               acc;
    #1;
    ev = '0; ed = '0; ad = '0;
    for (int k = 0; k < NC; k++) begin
      ev[k] = m_full[k];
      if (m_full[k]) begin
        ed[k*DW +: DW] = m_data[k];
        ad[k*DW +: DW] = out_data[k*DW +: DW];
      end
    end
    check("in_ready", 64'(in_ready), 64'(exp_ready()));
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data", 64'(ad), 64'(ed));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    acc = in_valid && exp_ready();
    for (int k = 0; k < NC; k++) begin
      if (rst) begin
        m_full[k] = 1'b0;
        m_data[k] = 8'h00;
      end else if (acc && (in_bcast || int'(in_sel) == k)) begin
        m_full[k] = 1'b1;
        m_data[k] = in_data;
      end else if (out_ready[k]) begin
        m_full[k] = 1'b0;
      end
    end
    if (rst) m_drop = 0;
    else if (acc && !in_bcast && int'(in_sel) >= NC && m_drop < 255) m_drop++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = SW'(sel);
    in_data  = d;
  endtask

  initial begin
    bit all_rdy, any_v;
    rst = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_sel = '0; in_data = '0;
    out_ready = '1; v6 = 1'b0; sel6 = '0; d6 = '0; ordy6 = '1;
    for (int k = 0; k < NC; k++) begin m_full[k] = 1'b0; m_data[k] = 8'h00; end
    m_drop = 0;
    @(negedge clk);
    tick();
    tick();
    #1;
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_data", 64'(out_data), 64'h0);
    check("rst_drop", 64'(drop_cnt), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h0);
    rst = 1'b0;

    // Single beat to channel 3, then it drains.
    send(3, 8'hA5); tick();
    in_valid = 1'b0;
    #1;
    check("b1_valid", 64'(out_valid), 64'h08);
    check("b1_data", 64'(out_data[3*DW +: DW]), 64'hA5);
    tick();
    check("b1_drain", 64'(out_valid), 64'h00);

    // Back-pressure on channel 2, then no-bubble refill.
    out_ready = 8'hFB;
    send(2, 8'h11); tick();
    in_data = 8'h22;
    #1;
    check("bp_ready_low", 64'(in_ready), 64'h0);
    tick(); tick();
    check("bp_hold", 64'(out_data[2*DW +: DW]), 64'h11);
    out_ready = 8'hFF;
    #1;
    check("bp_ready_high", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_refill_v", 64'(out_valid[2]), 64'h1);
    check("bp_refill_d", 64'(out_data[2*DW +: DW]), 64'h22);
    tick();

    // Stalled channel 5 does not block channel 1.
    out_ready = 8'hDF;
    send(5, 8'h44); tick();
    send(1, 8'h33); tick();
    in_valid = 1'b0;
    #1;
    check("ind_valid", 64'(out_valid), 64'h22);
    check("ind_ch5", 64'(out_data[5*DW +: DW]), 64'h44);
    check("ind_ch1", 64'(out_data[1*DW +: DW]), 64'h33);
    out_ready = 8'hFF;
    tick(); tick();

`ifdef DEMUX_BCAST_EN
    // Broadcast waits for every channel, then fills all of them.
    out_ready = 8'hFE;
    send(0, 8'h77); tick();
    send(6, 8'h5A); in_bcast = 1'b1;
    #1;
    check("bc_ready_low", 64'(in_ready), 64'h0);
    tick();
    out_ready = 8'hFF;
    #1;
    check("bc_ready_high", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    #1;
    check("bc_valid", 64'(out_valid), 64'hFF);
    check("bc_data", 64'(out_data), {8{8'h5A}});
    tick();
`endif

    // Reset while channels 0 and 4 are full and stalled.
    out_ready = 8'h00;
    send(0, 8'h01); tick();
    send(4, 8'h04); tick();
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'h11);
    rst = 1'b1; send(4, 8'h99); out_ready = 8'hFF;
    #1;
    check("rst_ready_low", 64'(in_ready), 64'h0);
    tick();
    check("rst2_valid", 64'(out_valid), 64'h0);
    check("rst2_drop", 64'(drop_cnt), 64'h0);
    check("rst2_ready", 64'(in_ready), 64'h0);
    rst = 1'b0; in_valid = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 60) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      in_sel    = SW'($urandom);
      in_data   = 8'($urandom);
      out_ready = NC'($urandom) | NC'($urandom);
`ifdef DEMUX_BCAST_EN
      in_bcast  = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; in_bcast = 1'b0;

    // Six-channel instance: out-of-range selects are dropped and counted.
    all_rdy = 1'b1; any_v = 1'b0;
    v6 = 1'b1; ordy6 = 6'h00;
    for (int i = 0; i < 300; i++) begin
      sel6 = (i % 2 == 0) ? 3'd7 : 3'd6;
      d6   = 8'(i);
      #1;
      if (!rdy6) all_rdy = 1'b0;
      if (ov6 != 6'h0) any_v = 1'b1;
      if (i == 10) check("drop_10", 64'(drop6), 64'd10);
      @(posedge clk);
      @(negedge clk);
    end
    v6 = 1'b0;
    #1;
    check("drop_ready", 64'(all_rdy), 64'h1);
    check("drop_novalid", 64'(any_v | (ov6 != 6'h0)), 64'h0);
    check("drop_sat", 64'(drop6), 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
